// File: rtl/lowpass_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lowpass_sequencer
// Brief   : 2-deep sample FIFO feeding a start/done filter, with busy timeout
//           and decimated result strobe.
// Revision: 1.0  initial release
// ============================================================================
module lowpass_sequencer #(
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 40
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               in_valid_in,
  input  logic signed [15:0] in_sample_in,
  output logic               in_ready_out,
  output logic               filt_ready_out,
  output logic signed [15:0] filt_sample_out,
  input  logic               filt_done_in,
  input  logic signed [15:0] filt_signal_in,
  output logic               out_valid_out,
  output logic signed [15:0] out_sample_out,
  output logic        [7:0]  drop_count_out,
  output logic               err_timeout_out
);

  localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);
  localparam logic [3:0] c_dec_last   = 4'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [15:0] r_fifo_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [7:0]         r_timer;
  logic [3:0]         r_dec_cnt;
  logic [7:0]         r_drop_count;
  logic               r_err_timeout;
  logic               r_out_valid;
  logic signed [15:0] r_out_sample;

  logic w_push;
  logic w_pop;
  logic w_fifo_nempty;
  logic w_timeout;

  assign in_ready_out    = (r_count < 2'd2);
  assign w_push          = in_valid_in & in_ready_out;
  assign w_pop           = (r_state == ISSUE);
  assign w_fifo_nempty   = (r_count != 2'd0);

  assign filt_ready_out  = (r_state == ISSUE);
  assign filt_sample_out = filt_ready_out ? r_fifo_mem[r_rd_ptr] : 16'sd0;
  assign out_valid_out   = r_out_valid;
  assign out_sample_out  = r_out_sample;
  assign drop_count_out  = r_drop_count;
  assign err_timeout_out = r_err_timeout;

  // Pop only happens in ISSUE, which is entered only with a non-empty FIFO.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_fifo_mem[0] <= 16'sd0;
      r_fifo_mem[1] <= 16'sd0;
      r_drop_count  <= 8'd0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= in_sample_in;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (in_valid_in && !in_ready_out && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fifo_nempty) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (filt_done_in) begin
          w_state_nxt = CAPTURE;
        end else if (r_timer == c_timer_last) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      CAPTURE: begin
        w_state_nxt = w_fifo_nempty ? ISSUE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The captured filter value goes straight to the output register once the
  // decimation count completes; intermediate results are discarded.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_timer       <= 8'd0;
      r_dec_cnt     <= 4'd0;
      r_err_timeout <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_sample  <= 16'sd0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == ISSUE) begin
        r_timer <= 8'd0;
      end else if ((r_state == BUSY) && !filt_done_in && !w_timeout) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (r_state == CAPTURE) begin
        if (r_dec_cnt == c_dec_last) begin
          r_dec_cnt    <= 4'd0;
          r_out_sample <= filt_signal_in;
          r_out_valid  <= 1'b1;
        end else begin
          r_dec_cnt <= r_dec_cnt + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lowpass_sequencer.sv
`default_nettype none
// Bench for lowpass_sequencer: a DECIM=1 and a DECIM=4 instance, each with a
// 31-cycle filter model; expectations come from queues of pushed values and results.
module tb_lowpass_sequencer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic rst_n_in;

  logic        a_valid;
  logic [15:0] a_sample;
  logic        a_spur;
  logic        a_respond;
  logic        a_mdone = 1'b0;
  logic [15:0] a_sig = 16'h0;
  wire         a_ready, a_fready, a_ovalid, a_err;
  wire  [15:0] a_fsample, a_osample;
  wire  [7:0]  a_drop;

  logic        b_valid;
  logic [15:0] b_sample;
  logic        b_mdone = 1'b0;
  logic [15:0] b_sig = 16'h0;
  wire         b_ready, b_fready, b_ovalid, b_err;
  wire  [15:0] b_fsample, b_osample;
  wire  [7:0]  b_drop;

  lowpass_sequencer #(.DECIM(1), .TIMEOUT(40)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid_in(a_valid), .in_sample_in(a_sample), .in_ready_out(a_ready),
    .filt_ready_out(a_fready), .filt_sample_out(a_fsample),
    .filt_done_in(a_mdone | a_spur), .filt_signal_in(a_sig),
    .out_valid_out(a_ovalid), .out_sample_out(a_osample),
    .drop_count_out(a_drop), .err_timeout_out(a_err)
  );

  lowpass_sequencer #(.DECIM(4), .TIMEOUT(40)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid_in(b_valid), .in_sample_in(b_sample), .in_ready_out(b_ready),
    .filt_ready_out(b_fready), .filt_sample_out(b_fsample),
    .filt_done_in(b_mdone), .filt_signal_in(b_sig),
    .out_valid_out(b_ovalid), .out_sample_out(b_osample),
    .drop_count_out(b_drop), .err_timeout_out(b_err)
  );

  // Issue/strobe logs and queued filter results per instance.
  int          a_it[$];
  logic [15:0] a_iv[$];
  int          a_ot[$];
  logic [15:0] a_ov[$];
  logic [15:0] a_res[$];
  int          a_due = -1;
  int          b_it[$];
  logic [15:0] b_iv[$];
  int          b_ot[$];
  logic [15:0] b_ov[$];
  logic [15:0] b_res[$];
  int          b_due = -1;

  // Filter model: done is seen by the DUT in cycle issue+31, result held afterwards.
  always @(negedge clk_in) begin
    a_mdone = 1'b0;
    if (!rst_n_in) begin
      a_due = -1;
    end else begin
      if (a_fready) begin
        a_it.push_back(cyc);
        a_iv.push_back(a_fsample);
        if (a_respond) a_due = cyc + 31;
      end
      if (a_due == cyc) begin
        a_mdone = 1'b1;
        a_sig   = (a_res.size() > 0) ? a_res.pop_front() : 16'h0;
        a_due   = -1;
      end
      if (a_ovalid) begin
        a_ot.push_back(cyc);
        a_ov.push_back(a_osample);
      end
    end
  end

  always @(negedge clk_in) begin
    b_mdone = 1'b0;
    if (!rst_n_in) begin
      b_due = -1;
    end else begin
      if (b_fready) begin
        b_it.push_back(cyc);
        b_iv.push_back(b_fsample);
        b_due = cyc + 31;
      end
      if (b_due == cyc) begin
        b_mdone = 1'b1;
        b_sig   = (b_res.size() > 0) ? b_res.pop_front() : 16'h0;
        b_due   = -1;
      end
      if (b_ovalid) begin
        b_ot.push_back(cyc);
        b_ov.push_back(b_osample);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic push_b(input logic [15:0] v);
    int n = 0;
    b_valid  = 1'b1;
    b_sample = v;
    while (!b_ready && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("push_b_accepted", {31'd0, b_ready}, 1);
    @(negedge clk_in);
  endtask

  initial begin
    int r, s, t, r2, r3, e, base_i, base_o;
    logic [15:0] x, y, w, p, q, qr;
    logic [15:0] v [3];
    logic [15:0] rv [3];
    logic [15:0] bv [8];
    logic [15:0] dec_exp[$];

    rst_n_in = 1'b0;
    a_valid = 1'b0; a_sample = 16'h0; a_spur = 1'b0; a_respond = 1'b1;
    b_valid = 1'b0; b_sample = 16'h0;
    repeat (3) @(negedge clk_in);

    chk("rst_in_ready",    {31'd0, a_ready},  1);
    chk("rst_filt_ready",  {31'd0, a_fready}, 0);
    chk("rst_filt_sample", {16'd0, a_fsample}, 0);
    chk("rst_out_valid",   {31'd0, a_ovalid}, 0);
    chk("rst_out_sample",  {16'd0, a_osample}, 0);
    chk("rst_drop",        {24'd0, a_drop},   0);
    chk("rst_err",         {31'd0, a_err},    0);

    // Single sample through DECIM=1 path
    x = 16'($urandom); y = 16'($urandom);
    a_res.push_back(y);
    r = cyc; rst_n_in = 1'b1; a_valid = 1'b1; a_sample = x;
    @(negedge clk_in); a_valid = 1'b0;
    chk("first_issue_not_early", {31'd0, a_fready}, 0);
    @(negedge clk_in);
    chk("issue_pulse",  {31'd0, a_fready}, 1);
    chk("issue_sample", {16'd0, a_fsample}, {16'd0, x});
    @(negedge clk_in);
    chk("issue_one_cycle",      {31'd0, a_fready}, 0);
    chk("sample_zero_outside",  {16'd0, a_fsample}, 0);
    wait_cyc(r + 34);
    chk("no_early_strobe", {31'd0, a_ovalid}, 0);
    @(negedge clk_in);
    chk("strobe_n33", {31'd0, a_ovalid}, 1);
    chk("result_n33", {16'd0, a_osample}, {16'd0, y});
    @(negedge clk_in);
    chk("strobe_one_cycle", {31'd0, a_ovalid}, 0);
    chk("result_held",      {16'd0, a_osample}, {16'd0, y});

    // Three back-to-back beats while idle
    for (int i = 0; i < 3; i++) begin
      v[i]  = 16'($urandom);
      rv[i] = 16'($urandom);
      a_res.push_back(rv[i]);
    end
    base_i = a_it.size(); base_o = a_ot.size();
    s = cyc; a_valid = 1'b1; a_sample = v[0];
    @(negedge clk_in);
    chk("b2b_ready_after_1", {31'd0, a_ready}, 1);
    a_sample = v[1];
    @(negedge clk_in);
    chk("b2b_ready_low_after_2", {31'd0, a_ready}, 0);
    a_sample = v[2];
    @(negedge clk_in);
    chk("b2b_ready_after_pop", {31'd0, a_ready}, 1);
    @(negedge clk_in);
    a_valid = 1'b0;
    chk("b2b_drop_one", {24'd0, a_drop}, 1);
    wait_cyc(s + 104);
    chk("b2b_issue_count", a_it.size() - base_i, 3);
    chk("b2b_strobe_count", a_ot.size() - base_o, 3);
    for (int i = 0; i < 3 && base_i + i < a_it.size(); i++) begin
      chk("b2b_issue_order", {16'd0, a_iv[base_i + i]}, {16'd0, v[i]});
      chk("b2b_issue_time", a_it[base_i + i] - s, 2 + 33 * i);
    end
    for (int i = 0; i < 3 && base_o + i < a_ot.size() && base_i + i < a_it.size(); i++) begin
      chk("b2b_result", {16'd0, a_ov[base_o + i]}, {16'd0, rv[i]});
      chk("b2b_result_latency", a_ot[base_o + i] - a_it[base_i + i], 33);
    end

    // Filter never responds: timeout, reissue, drop saturation
    a_respond = 1'b0;
    w = 16'($urandom);
    t = cyc; a_valid = 1'b1; a_sample = w;
    wait_cyc(t + 2);
    chk("to_issue",        {31'd0, a_fready}, 1);
    chk("to_issue_sample", {16'd0, a_fsample}, {16'd0, w});
    wait_cyc(t + 42);
    chk("to_err_not_yet", {31'd0, a_err}, 0);
    wait_cyc(t + 43);
    chk("to_err_set",     {31'd0, a_err},    1);
    chk("to_no_start",    {31'd0, a_fready}, 0);
    wait_cyc(t + 44);
    chk("to_reissue",        {31'd0, a_fready}, 1);
    chk("to_reissue_sample", {16'd0, a_fsample}, {16'd0, w});
    wait_cyc(t + 300);
    a_valid = 1'b0;
    chk("drop_saturated", {24'd0, a_drop}, 255);
    chk("err_sticky",     {31'd0, a_err},  1);
    chk("to_no_result", a_ot.size() - base_o, 3);

    // Asynchronous reset clears sticky state immediately
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("rst2_err",   {31'd0, a_err},   0);
    chk("rst2_drop",  {24'd0, a_drop},  0);
    chk("rst2_ready", {31'd0, a_ready}, 1);
    chk("rst2_b_err",  {31'd0, b_err},  0);
    chk("rst2_b_drop", {24'd0, b_drop}, 0);

    // Reset in BUSY cycle 10, then spurious done while idle
    @(negedge clk_in);
    p = 16'($urandom);
    r2 = cyc; rst_n_in = 1'b1; a_valid = 1'b1; a_sample = p;
    @(negedge clk_in); a_valid = 1'b0;
    wait_cyc(r2 + 2);
    chk("d_issue", {31'd0, a_fready}, 1);
    wait_cyc(r2 + 12);
    rst_n_in = 1'b0;
    #1;
    chk("d_rst_out_valid", {31'd0, a_ovalid}, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    base_i = a_it.size(); base_o = a_ot.size();
    wait_cyc(r2 + 15);
    a_spur = 1'b1;
    @(negedge clk_in);
    a_spur = 1'b0;
    wait_cyc(r2 + 60);
    chk("d_no_issue",   a_it.size() - base_i, 0);
    chk("d_no_strobe",  a_ot.size() - base_o, 0);
    chk("d_out_sample", {16'd0, a_osample}, 0);
    chk("d_in_ready",   {31'd0, a_ready},   1);
    chk("d_err",        {31'd0, a_err},     0);

    // Normal operation resumes after the spurious done
    a_respond = 1'b1;
    q = 16'($urandom); qr = 16'($urandom);
    a_res.push_back(qr);
    r3 = cyc; a_valid = 1'b1; a_sample = q;
    @(negedge clk_in); a_valid = 1'b0;
    wait_cyc(r3 + 2);
    chk("e_issue",        {31'd0, a_fready}, 1);
    chk("e_issue_sample", {16'd0, a_fsample}, {16'd0, q});
    wait_cyc(r3 + 35);
    chk("e_strobe", {31'd0, a_ovalid}, 1);
    chk("e_result", {16'd0, a_osample}, {16'd0, qr});

    // DECIM=4: eight samples, filter returns 1..8
    for (int i = 0; i < 8; i++) begin
      bv[i] = 16'($urandom);
      b_res.push_back(16'(i + 1));
      if ((i + 1) % 4 == 0) dec_exp.push_back(16'(i + 1));
    end
    e = cyc;
    for (int i = 0; i < 8; i++) push_b(bv[i]);
    b_valid = 1'b0;
    wait_cyc(e + 310);
    chk("dec_issue_count",  b_it.size(), 8);
    chk("dec_strobe_count", b_ot.size(), dec_exp.size());
    for (int i = 0; i < 8 && i < b_it.size(); i++) begin
      chk("dec_issue_order", {16'd0, b_iv[i]}, {16'd0, bv[i]});
    end
    for (int i = 1; i < 8 && i < b_it.size(); i++) begin
      chk("dec_issue_spacing_min", {31'd0, (b_it[i] - b_it[i - 1]) >= 33}, 1);
    end
    for (int i = 0; i < dec_exp.size() && i < b_ot.size(); i++) begin
      chk("dec_strobe_value", {16'd0, b_ov[i]}, {16'd0, dec_exp[i]});
    end
    if (b_ot.size() == 2 && b_it.size() == 8) begin
      chk("dec_strobe_latency", b_ot[1] - b_it[7], 33);
    end
    chk("dec_held", {16'd0, b_osample}, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/lowpass_sequencer.md
LOWPASS_SEQUENCER -- requirements
Module: lowpass_sequencer

Interface
REQ-001 Parameter DECIM, default 1, output decimation factor, legal 1..16.
REQ-002 Parameter TIMEOUT, default 40, max BUSY cycles waiting for filter done, legal 32..255.
REQ-003 clk_in  input  1  single clock; all logic on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_in  input  1  upstream sample valid.
REQ-006 in_sample_in  input  16  signed upstream sample.
REQ-007 in_ready_out  output  1  sequencer can accept a sample this cycle.
REQ-008 filt_ready_out  output  1  one-cycle start pulse to filter ready_in.
REQ-009 filt_sample_out  output  16  signed sample to filter signal_in, valid while filt_ready_out=1.
REQ-010 filt_done_in  input  1  filter done_out pulse.
REQ-011 filt_signal_in  input  16  signed filter signal_out.
REQ-012 out_valid_out  output  1  one-cycle result strobe.
REQ-013 out_sample_out  output  16  signed filtered (decimated) result, held between strobes.
REQ-014 drop_count_out  output  8  saturating count of refused input beats.
REQ-015 err_timeout_out  output  1  sticky timeout flag.

Function
REQ-016 Input FIFO: 2 entries x 16 bits; push when in_valid_in & in_ready_out; in_ready_out = (count<2), combinational from count only.
REQ-017 Simultaneous push and pop: count unchanged, order preserved, no data loss.
REQ-018 in_valid_in=1 while in_ready_out=0: drop_count_out +1, saturating at 255.
REQ-019 FSM states IDLE, ISSUE, BUSY, CAPTURE.
REQ-020 IDLE: FIFO non-empty -> ISSUE; else stay.
REQ-021 ISSUE (exactly 1 cycle): filt_ready_out=1, filt_sample_out=FIFO head, pop head, clear timer -> BUSY.
REQ-022 BUSY: filt_done_in=1 -> CAPTURE; else timer+1; timer reaching TIMEOUT-1 without done -> set err_timeout_out, -> IDLE, no result produced.
REQ-023 filt_done_in outside BUSY: ignored.
REQ-024 CAPTURE (1 cycle, the cycle after done): register filt_signal_in as candidate result; decimation counter +1.
REQ-025 Decimation counter reaching DECIM-1 in CAPTURE: out_sample_out <= candidate, out_valid_out=1 next cycle, counter -> 0; otherwise no strobe, out_sample_out held.
REQ-026 CAPTURE exit: FIFO non-empty -> ISSUE, else IDLE.
REQ-027 Filter handshake timing: with the team filter (31 work cycles), ISSUE in cycle N gives done in N+31, CAPTURE in N+32, out_valid_out in N+33, next ISSUE no earlier than N+33.
REQ-028 filt_ready_out never asserted outside ISSUE; never two starts without an intervening done or timeout.
REQ-029 filt_sample_out = 0 outside ISSUE.
REQ-030 err_timeout_out cleared only by reset.

Reset
REQ-031 rst_n_in=0 asynchronously: FSM -> IDLE, FIFO empty, timer and decimation counter 0, filt_ready_out 0, out_valid_out 0, out_sample_out 0, drop_count_out 0, err_timeout_out 0.
REQ-032 Reset mid-BUSY: in-flight sample discarded; no out_valid_out for it after release.
REQ-033 First ISSUE no earlier than the second rising edge after rst_n_in deasserts.

Verification
REQ-034 DECIM=1, push 100, model filter returns done 31 cycles after start with 25 -> filt_ready_out cycle N with filt_sample_out=100, out_valid_out at N+33 with out_sample_out=25.
REQ-035 Push 3 samples back-to-back while idle -> in_ready_out low after the 2nd accepted beat until first ISSUE pop, third beat stalls; all 3 issued in order, ISSUE spacing 33 cycles.
REQ-036 Hold in_valid_in=1 for 300 cycles with filter never responding -> drop_count_out saturates at 255, err_timeout_out=1 after 40 BUSY cycles, FSM returns IDLE and reissues.
REQ-037 DECIM=4, 8 samples, filter returns 1..8 -> exactly 2 out_valid_out strobes with 4 then 8.
REQ-038 Assert rst_n_in=0 at BUSY cycle 10, release, then spurious filt_done_in -> no out_valid_out, all outputs at reset values.
REQ-039 filt_done_in pulse while IDLE with FIFO empty -> no state change, no strobe.
